// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencing controller for the 5-stage CPU. Resolves the hazards
//   forwarding cannot: load-use stalls, taken-branch flushes and multicycle
//   mul/div occupancy of EX.
//
//   Optional feature: define HAZARD_STALL_COUNTER_EN to build the saturating
//   stall performance counter; otherwise Stall_Cycles is tied to 0.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   RUN     | normal flow; detects mul/div start, branch flush, load-use
//   MD_BUSY | mul/div occupying EX; front of pipe frozen, EX/MEM bubbled
//   MD_LAST | mul/div result valid this cycle; pipeline advances
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   IF_ID_RegisterRs/Rt       source registers of the instruction in ID
//   IF_ID_UsesRt              ID instruction reads rt
//   ID_EX_MemRead/RegisterRt  load in EX and its destination
//   ID_EX_IsMulDiv            mul/div in EX
//   Branch_Taken              branch in EX resolved taken
//   PCWrite, IF_ID_Write, ID_EX_Write          pipeline register enables
//   IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble   NOP insertion controls
//   MD_Start, MD_Busy         mul/div start pulse and busy indication
//   Stall_Cycles              count of cycles with PCWrite=0
module hazard_controller #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        IF_ID_UsesRt,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic        ID_EX_IsMulDiv,
  input  logic        Branch_Taken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Write,
  output logic        ID_EX_Bubble,
  output logic        EX_MEM_Bubble,
  output logic        MD_Start,
  output logic        MD_Busy,
  output logic [31:0] Stall_Cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_LAST = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lu;

  // $0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
              ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
               (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ID_EX_IsMulDiv) begin
            // Start cycle counts as the first of MD_CYCLES; MD_LAST the final.
            if (MD_CYCLES > 2) begin
              state <= MD_BUSY;
              cnt   <= CNT_W'(MD_CYCLES - 2);
            end else begin
              state <= MD_LAST;
            end
          end
        end
        MD_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= MD_LAST;
        end
        MD_LAST: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MD_Start      = 1'b0;
    MD_Busy       = 1'b0;
    case (state)
      RUN: begin
        if (ID_EX_IsMulDiv) begin
          MD_Start      = 1'b1;
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Bubble = 1'b1;
        end else if (Branch_Taken) begin
          // Flush wins over load-use: the dependent instruction is discarded.
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
        end else if (lu) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
      end
      MD_BUSY: begin
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        EX_MEM_Bubble = 1'b1;
        MD_Busy       = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!PCWrite && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign Stall_Cycles = stall_cnt;
`else
  assign Stall_Cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (MD_CYCLES=4 and MD_CYCLES=2)
// share stimulus and are compared against a cycle-count reference model.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, lrt;
  logic       uses_rt, mem_read, is_md, br;

  logic        pcw4, ifw4, iff4, idw4, idb4, exb4, mds4, mdb4;
  logic        pcw2, ifw2, iff2, idw2, idb2, exb2, mds2, mdb2;
  logic [31:0] st4, st2;
  logic [7:0]  pack4, pack2;

  int checks = 0;
  int errors = 0;
  int left4, left2;
  int stall4, stall2;

  always #5 clk = ~clk;

  hazard_controller #(.MD_CYCLES(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses_rt),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRt(lrt),
    .ID_EX_IsMulDiv(is_md), .Branch_Taken(br),
    .PCWrite(pcw4), .IF_ID_Write(ifw4), .IF_ID_Flush(iff4),
    .ID_EX_Write(idw4), .ID_EX_Bubble(idb4), .EX_MEM_Bubble(exb4),
    .MD_Start(mds4), .MD_Busy(mdb4), .Stall_Cycles(st4)
  );

  hazard_controller #(.MD_CYCLES(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses_rt),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRt(lrt),
    .ID_EX_IsMulDiv(is_md), .Branch_Taken(br),
    .PCWrite(pcw2), .IF_ID_Write(ifw2), .IF_ID_Flush(iff2),
    .ID_EX_Write(idw2), .ID_EX_Bubble(idb2), .EX_MEM_Bubble(exb2),
    .MD_Start(mds2), .MD_Busy(mdb2), .Stall_Cycles(st2)
  );

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
  //  EX_MEM_Bubble, MD_Start, MD_Busy}
  assign pack4 = {pcw4, ifw4, iff4, idw4, idb4, exb4, mds4, mdb4};
  assign pack2 = {pcw2, ifw2, iff2, idw2, idb2, exb2, mds2, mdb2};

  localparam logic [7:0] O_RUN   = 8'b1101_0000;
  localparam logic [7:0] O_START = 8'b0000_0110;
  localparam logic [7:0] O_BUSY  = 8'b0000_0101;
  localparam logic [7:0] O_FLUSH = 8'b1111_1000;
  localparam logic [7:0] O_LU    = 8'b0001_1000;

  // Model: 'left' = EX cycles still owed to an in-flight mul/div after this one.
  function automatic logic [7:0] exp_out(int left);
    logic hit;
    hit = mem_read && (lrt != 0) &&
          ((lrt == rs) || (uses_rt && (lrt == rt)));
    if (left > 1) return O_BUSY;
    if (left == 1) return O_RUN;
    if (is_md) return O_START;
    if (br) return O_FLUSH;
    if (hit) return O_LU;
    return O_RUN;
  endfunction

  function automatic int next_left(int left, int cycles);
    if (left > 0) return left - 1;
    if (is_md) return cycles - 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_stall(int n);
`ifdef HAZARD_STALL_COUNTER_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] i_rs, input logic [4:0] i_rt, input logic i_ut,
                       input logic i_mr, input logic [4:0] i_lrt,
                       input logic i_md, input logic i_br);
    rs = i_rs; rt = i_rt; uses_rt = i_ut; mem_read = i_mr;
    lrt = i_lrt; is_md = i_md; br = i_br;
  endtask

  // Check outputs mid-cycle, take the edge, advance the model.
  task automatic cycle(input string tag);
    logic [7:0] e4, e2;
    #1;
    e4 = exp_out(left4);
    e2 = exp_out(left2);
    chk({tag, "/out4"}, 32'(pack4), 32'(e4));
    chk({tag, "/out2"}, 32'(pack2), 32'(e2));
    chk({tag, "/stall4"}, st4, exp_stall(stall4));
    chk({tag, "/stall2"}, st2, exp_stall(stall2));
    @(posedge clk);
    if (!e4[7]) stall4++;
    if (!e2[7]) stall2++;
    left4 = next_left(left4, 4);
    left2 = next_left(left2, 2);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    left4 = 0; left2 = 0; stall4 = 0; stall2 = 0;
    #2;
    chk("reset/out4", 32'(pack4), 32'(O_RUN));
    chk("reset/out2", 32'(pack2), 32'(O_RUN));
    chk("reset/stall4", st4, 32'd0);
    #20 rst = 1'b1;

    // load-use: lw $5 in EX, add rs=5 in ID -> one stall cycle then flow
    drive(5, 7, 1, 1, 5, 0, 0);  cycle("lu_rs");
    chk("lu_rs/pcw", 32'(pcw4), 32'd0);
    drive(5, 7, 1, 0, 5, 0, 0);  cycle("lu_after");
    // $0 never triggers, rt match ignored when rt unused
    drive(0, 3, 1, 1, 0, 0, 0);  cycle("lu_zero");
    drive(2, 9, 0, 1, 9, 0, 0);  cycle("rt_unused");
    drive(2, 9, 1, 1, 9, 0, 0);  cycle("lu_rt");
    // branch beats load-use
    drive(5, 0, 0, 1, 5, 0, 1);  cycle("br_lu");

    // counter scenario from a clean reset: one load-use + one mul/div
    rst = 1'b0; #1; rst = 1'b1;
    left4 = 0; left2 = 0; stall4 = 0; stall2 = 0;
    drive(4, 0, 0, 1, 4, 0, 0);  cycle("cnt_lu");
    drive(0, 0, 0, 0, 0, 1, 0);  cycle("md_start");
    drive(0, 0, 0, 1, 0, 0, 1);  cycle("md_busy1");
    drive(1, 1, 1, 1, 1, 0, 1);  cycle("md_busy2");
    drive(0, 0, 0, 0, 0, 0, 0);  cycle("md_last");
    chk("cnt_total4", st4, exp_stall(4));
    chk("cnt_total2", st2, exp_stall(2));
    drive(0, 0, 0, 0, 0, 0, 0);  cycle("md_run");
    // back-to-back mul/div
    drive(0, 0, 0, 0, 0, 1, 0);  cycle("b2b_a");
    cycle("b2b_b"); cycle("b2b_c"); cycle("b2b_d");
    drive(0, 0, 0, 0, 0, 0, 0);  cycle("b2b_e");

    // asynchronous reset in the middle of MD_BUSY
    drive(0, 0, 0, 0, 0, 1, 0);  cycle("rmid_start");
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rmid_busy", 32'(mdb4), 32'd1);
    rst = 1'b0;
    #1;
    chk("rmid/out4", 32'(pack4), 32'(O_RUN));
    chk("rmid/out2", 32'(pack2), 32'(O_RUN));
    chk("rmid/stall4", st4, 32'd0);
    left4 = 0; left2 = 0; stall4 = 0; stall2 = 0;
    @(negedge clk);
    #1 rst = 1'b1;
    cycle("rmid_after");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller sitting beside the forwarding unit in the 5-stage CPU.
- Resolves the hazards that forwarding cannot:
  - load-use stalls;
  - taken-branch flushes;
  - multicycle mul/div occupancy of EX.
- Drives the pipeline-register write enables, bubble/flush controls and the mul/div start pulse.

Parameters:
- MD_CYCLES, 32: EX occupancy of a mul/div op in cycles; legal range 2..255.
- CNT_W, 8: width of the internal mul/div down-counter; must hold MD_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset; rst=0 resets immediately
- IF_ID_RegisterRs  input  5  rs of instruction in ID
- IF_ID_RegisterRt  input  5  rt of instruction in ID
- IF_ID_UsesRt  input  1  ID instruction reads rt as a source
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegisterRt  input  5  load destination in EX
- ID_EX_IsMulDiv  input  1  instruction in EX is mul/div
- Branch_Taken  input  1  branch in EX resolved taken this cycle
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register enable
- IF_ID_Flush  output  1  load NOP into IF/ID
- ID_EX_Write  output  1  ID/EX register enable
- ID_EX_Bubble  output  1  load NOP control into ID/EX
- EX_MEM_Bubble  output  1  load NOP control into EX/MEM
- MD_Start  output  1  one-cycle start pulse to mul/div unit
- MD_Busy  output  1  high while the FSM is in MD_BUSY
- Stall_Cycles  output  32  stall performance counter (optional feature)

Behaviour:
- FSM states: RUN, MD_BUSY, MD_LAST. Down-counter cnt[CNT_W-1:0].
- Reset (rst=0, asynchronous):
  - state=RUN, cnt=0, Stall_Cycles=0.
  - Outputs take RUN values with no hazard: PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, all bubbles/flush=0, MD_Start=0, MD_Busy=0.
  - Reset mid mul/div abandons the operation; no MD_Start on the first cycle after reset release unless ID_EX_IsMulDiv=1.
- Outputs are combinational from state and inputs; only state, cnt and Stall_Cycles are registered.
- Load-use condition LU = ID_EX_MemRead && ID_EX_RegisterRt!=0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || (IF_ID_UsesRt && ID_EX_RegisterRt==IF_ID_RegisterRt)).
- RUN, priority high to low:
  1. ID_EX_IsMulDiv=1: MD_Start=1; PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1.
     - MD_CYCLES>2: next state=MD_BUSY, cnt<=MD_CYCLES-2.
     - MD_CYCLES=2: next state=MD_LAST.
  2. Branch_Taken=1: PCWrite=1, IF_ID_Flush=1, ID_EX_Bubble=1. The flush overrides LU in the same cycle.
  3. LU=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Single cycle only; next cycle the load is in MEM and forwarding covers it.
  4. Otherwise: all enables=1, no bubbles.
- MD_BUSY:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1, MD_Busy=1, MD_Start=0.
  - cnt decrements each cycle; when cnt==1, next state=MD_LAST.
  - Branch_Taken and LU are ignored (EX holds the mul/div, so neither can be valid).
- MD_LAST:
  - Result is valid; all enables=1, EX_MEM_Bubble=0, MD_Busy=0. The mul/div advances to MEM.
  - Next state=RUN unconditionally.
  - Back-to-back mul/div restarts from RUN on the following cycle.
- Total EX occupancy of one mul/div = exactly MD_CYCLES cycles (start cycle + busy cycles + last cycle).
- Register $0 never triggers LU.

Optional Feature:
- Macro HAZARD_STALL_COUNTER_EN.
- Defined: Stall_Cycles increments on every clock where PCWrite=0, saturating at 32'hFFFF_FFFF; cleared only by reset.
- Undefined: the counter is not instantiated and Stall_Cycles is constant 0.

Test Plan:
- Load-use: lw $5 in EX (ID_EX_MemRead=1, Rt=5) with add using rs=5 in ID -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle all enables=1.
- $0 and no-rt cases:
  - load Rt=0 matching rs=0 -> no stall;
  - IF_ID_UsesRt=0 with rt match only -> no stall.
- Branch priority: Branch_Taken=1 and LU=1 in the same cycle -> PCWrite=1, IF_ID_Flush=1, ID_EX_Bubble=1, no stall.
- Mul/div with MD_CYCLES=4: ID_EX_IsMulDiv=1 in RUN -> MD_Start for one cycle, MD_Busy for 2 cycles, MD_LAST on cycle 4 with enables=1, then RUN; PCWrite=0 for exactly 3 cycles.
- Reset mid-op: rst=0 during MD_BUSY -> all outputs return to reset values asynchronously, before the next clk edge; Stall_Cycles=0.
- Counter (HAZARD_STALL_COUNTER_EN defined): one load-use stall plus a 4-cycle mul/div -> Stall_Cycles=4. Same run with the macro undefined -> Stall_Cycles=0.
